ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
- Registered unsigned WIDTH-bit adder; the carry propagates bit-serially through a chain of 1-bit full-adder cells, with no lookahead.
- Sits in the arithmetic datapath as the baseline adder ("method 1") against which faster adder variants are compared.
- The result and carry-out are captured in output registers, giving one cycle of latency, and are qualified by a valid flag.

Parameters:
- WIDTH, 64, operand and sum width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands on a/b are valid this cycle.
- a  input  WIDTH  first unsigned operand.
- b  input  WIDTH  second unsigned operand.
- sum  output  WIDTH  registered (a+b) mod 2^WIDTH.
- co  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  sum/co hold a fresh result.

Behaviour:
- Combinational core:
  - c[0]=0.
  - For i in 0..WIDTH-1: s[i]=a[i]^b[i]^c[i], c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])).
  - co_next=c[WIDTH].
  - No '+' operator on the full vectors; the chain is explicit, one full_adder per bit.
- Reset: while rst_n=0 (asserted asynchronously, released synchronously to clk), sum=0, co=0, out_valid=0.
- Capture: on each rising clk edge with in_valid=1, sum<=s and co<=co_next. Latency is exactly 1 cycle.
- Hold: with in_valid=0, sum and co hold their last values.
- Valid flag: out_valid<=in_valid on every edge. A one-cycle in_valid pulse gives a one-cycle out_valid pulse; back-to-back valids give a result every cycle.
- Handshake: no backpressure or ready signal. The block always accepts input.
- Wrap-around: the sum is modulo 2^WIDTH and the overflow appears only on co. Example: all-ones + 1 -> sum=0, co=1.
- Reset mid-operation: an in-flight result is discarded. Outputs go to 0 immediately. The first valid after rst_n deasserts produces a normal result one cycle later.
- X-safety: outputs are never X after reset, regardless of a/b.

Optional Feature:
- Macro RCA_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit), the registered signed overflow c[WIDTH]^c[WIDTH-1].
  - Captured under the same in_valid rule.
  - Reset value 0.
- Undefined: the ovf port does not exist. All other behaviour is identical.

Decomposition:
- Shared package rca_pkg:
  - localparam RCA_DEFAULT_WIDTH=64.
  - typedef logic [RCA_DEFAULT_WIDTH-1:0] rca_word_t, used by benches and sibling adders.
- Sub-module full_adder (inputs a, b, cin; outputs s, cout) instantiated WIDTH times in a generate loop.
- Top level holds only the chain wiring and output registers.

Test Plan:
- Reset: hold rst_n=0 with a=5, b=7, in_valid=1 -> sum=0, co=0, out_valid=0 throughout. Release, then one edge later sum=12, co=0, out_valid=1.
- Small operands, one per cycle: (1,1), (1,2), (1,3), (1,4), (1,50), (1,55), (10,10), (15,30), (25,52), (60,17) -> one cycle after each, sum=2, 3, 4, 5, 51, 56, 20, 45, 77, 77, co=0, out_valid=1.
- Full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, co=1. Also a=b=all-ones -> sum=64'hFFFF_FFFF_FFFF_FFFE, co=1.
- Hold: apply (3,4) with in_valid=1, then change to (100,200) with in_valid=0 -> sum stays 7, out_valid drops to 0 the next cycle.
- Async reset mid-stream: assert rst_n=0 between edges while sum=77 -> sum, co and out_valid clear before the next edge.
- With RCA_OVERFLOW_EN: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> ovf=1, co=0. Then a=64'h8000_0000_0000_0000, b=64'h8000_0000_0000_0000 -> sum=0, co=1, ovf=1.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder and its sibling adder variants.
package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 64;

  typedef logic [RCA_DEFAULT_WIDTH-1:0] rca_word_t;

endpackage : rca_pkg

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full-adder cell; one instance per bit forms the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// Registered WIDTH-bit ripple-carry adder, one cycle of latency, valid-qualified.
// Optional registered signed-overflow output ovf when RCA_OVERFLOW_EN is defined.
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             co,
`ifdef RCA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s;

  assign carry[0] = 1'b0;

  // Carry ripples strictly bit by bit; no lookahead anywhere in the chain.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (s[i]),
      .cout (carry[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             co_d, co_q;
  logic             valid_q;

  // NOTE: every always_comb output gets a default first (the hold value), so no latch is inferred.
  always_comb begin
    sum_d = sum_q;
    co_d  = co_q;
    if (in_valid) begin
      sum_d = s;
      co_d  = carry[WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      co_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      co_q    <= co_d;
      valid_q <= in_valid;
    end
  end

  assign sum       = sum_q;
  assign co        = co_q;
  assign out_valid = valid_q;

`ifdef RCA_OVERFLOW_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder against an arithmetic reference model.
// Define RCA_OVERFLOW_EN to also exercise the ovf output.
module tb_ripple_carry_adder;
  import rca_pkg::*;

  localparam int W = RCA_DEFAULT_WIDTH;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      in_valid = 1'b0;
  rca_word_t a = '0;
  rca_word_t b = '0;
  rca_word_t sum;
  logic      co;
  logic      out_valid;
`ifdef RCA_OVERFLOW_EN
  logic      ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs should show after the most recent edge.
  rca_word_t exp_sum   = '0;
  logic      exp_co    = 1'b0;
  logic      exp_ovf   = 1'b0;
  logic      exp_valid = 1'b0;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .co        (co),
`ifdef RCA_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d required to finish earlier", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W:0] observed, input logic [W:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".sum"}, {1'b0, sum}, {1'b0, exp_sum});
    check({tag, ".co"}, {{W{1'b0}}, co}, {{W{1'b0}}, exp_co});
    check({tag, ".valid"}, {{W{1'b0}}, out_valid}, {{W{1'b0}}, exp_valid});
`ifdef RCA_OVERFLOW_EN
    check({tag, ".ovf"}, {{W{1'b0}}, ovf}, {{W{1'b0}}, exp_ovf});
`endif
  endtask

  task automatic model_reset();
    exp_sum   = '0;
    exp_co    = 1'b0;
    exp_ovf   = 1'b0;
    exp_valid = 1'b0;
  endtask

  // Unsigned (a+b) mod 2^W with carry on co; signed overflow when like-signed
  // operands give a result of the opposite sign.
  task automatic model_edge(input rca_word_t ma, input rca_word_t mb, input logic mv);
    logic [W:0] full;
    exp_valid = mv;
    if (mv) begin
      full    = {1'b0, ma} + {1'b0, mb};
      exp_sum = full[W-1:0];
      exp_co  = full[W];
      exp_ovf = (ma[W-1] == mb[W-1]) && (exp_sum[W-1] != ma[W-1]);
    end
  endtask

  task automatic apply(input rca_word_t na, input rca_word_t nb, input logic nv, input string tag);
    @(negedge clk);
    a        = na;
    b        = nb;
    in_valid = nv;
    @(posedge clk);
    model_edge(na, nb, nv);
    #1;
    check_outputs(tag);
  endtask

  function automatic rca_word_t rand_word();
    rca_word_t w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: w = '1;
      1: w = '0;
      2: w = {1'b0, {(W-1){1'b1}}};
      3: w = {1'b1, {(W-1){1'b0}}};
      default: ;
    endcase
    return w;
  endfunction

  rca_word_t small_a [10] = '{1, 1, 1, 1, 1, 1, 10, 15, 25, 60};
  rca_word_t small_b [10] = '{1, 2, 3, 4, 50, 55, 10, 30, 52, 17};
  rca_word_t small_s [10] = '{2, 3, 4, 5, 51, 56, 20, 45, 77, 77};

  initial begin
    // Reset held with a valid operand pair present: outputs stay cleared.
    rst_n    = 1'b0;
    a        = 5;
    b        = 7;
    in_valid = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outputs("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset.sum", {1'b0, sum}, 65'd12);
    check("post_reset.co", {{W{1'b0}}, co}, '0);
    check("post_reset.valid", {{W{1'b0}}, out_valid}, 65'd1);
    model_edge(5, 7, 1'b1);

    // Small operands, back to back, with fixed expected sums.
    for (int i = 0; i < 10; i++) begin
      apply(small_a[i], small_b[i], 1'b1, "small");
      check("small.fixed", {1'b0, sum}, {1'b0, small_s[i]});
    end

    // Full carry ripple across every bit.
    apply('1, 64'd1, 1'b1, "ripple_one");
    check("ripple_one.fixed", {co, sum}, {1'b1, 64'd0});
    apply('1, '1, 1'b1, "ripple_ones");
    check("ripple_ones.fixed", {co, sum}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});

    // Hold: with in_valid low the last result persists and valid drops.
    apply(3, 4, 1'b1, "hold_load");
    apply(100, 200, 1'b0, "hold");
    check("hold.fixed", {out_valid, sum}, {1'b0, 64'd7});
    apply(100, 200, 1'b0, "hold2");

    // Asynchronous reset between edges clears outputs before the next edge.
    apply(25, 52, 1'b1, "pre_async");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply(40, 2, 1'b1, "after_async");
    check("after_async.fixed", {1'b0, sum}, 65'd42);

    // Signed-overflow corner cases.
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, "ovf_pos");
    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, "ovf_neg");
    check("ovf_neg.fixed", {co, sum}, {1'b1, 64'd0});
`ifdef RCA_OVERFLOW_EN
    check("ovf_neg.ovf_fixed", {{W{1'b0}}, ovf}, 65'd1);
`endif
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, "ovf_none");

    // Randomized operands and valid pattern against the reference model.
    for (int i = 0; i < 300; i++) begin
      apply(rand_word(), rand_word(), 1'($urandom_range(0, 3) != 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ripple_carry_adder
